// File: rtl/axi_slave_ooo_mem.sv
// axi_slave_ooo_mem: AXI-lite word memory with in-order buffered writes and ID-latency out-of-order reads
module axi_slave_ooo_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 2,
  parameter int MEM_WORDS = 16,
  parameter int N_SLOTS = 4,
  parameter int WR_FIFO_DEPTH = 2,
  parameter int B_MAX = 4,
  parameter int LAT_BASE = 0,
  parameter int LAT_STEP = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [ID_W-1:0]   arid,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic [ID_W-1:0]   rid,
  output logic              rvalid,
  input  logic              rready,
  output logic              bvalid,
  input  logic              bready
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int FW = WR_FIFO_DEPTH > 1 ? $clog2(WR_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(WR_FIFO_DEPTH + 1);
  localparam int BW = $clog2(B_MAX + 1);
  localparam int PW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  localparam int SW = $clog2(N_SLOTS) + 1;
  localparam int LMAX = LAT_BASE + LAT_STEP * (2**ID_W - 1);
  localparam int LW = LMAX > 0 ? $clog2(LMAX + 1) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [IW-1:0] aw_q [WR_FIFO_DEPTH];
  logic [DATA_W-1:0] w_q [WR_FIFO_DEPTH];
  logic [FW-1:0] aw_wp, aw_rp, w_wp, w_rp;
  logic [CW-1:0] aw_cnt, w_cnt;
  logic [BW-1:0] b_pending;
  logic [N_SLOTS-1:0] s_vld;
  logic [ID_W-1:0] s_id [N_SLOTS];
  logic [DATA_W-1:0] s_data [N_SLOTS];
  logic [LW-1:0] s_cnt [N_SLOTS];
  logic [SW-1:0] s_seq [N_SLOTS];
  logic [SW-1:0] seq_ctr, age;
  logic [PW-1:0] alloc, pick;
  logic pick_ok, load, commit, unused_addr;

  function automatic logic [FW-1:0] inc(input logic [FW-1:0] p);
    return p == FW'(WR_FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign awready = aw_cnt != CW'(WR_FIFO_DEPTH);
  assign wready = w_cnt != CW'(WR_FIFO_DEPTH);
  assign arready = ~&s_vld;
  assign bvalid = b_pending != '0;
  assign commit = aw_cnt != '0 && w_cnt != '0 && b_pending < BW'(B_MAX);
  assign load = pick_ok && (!rvalid || rready);
  assign unused_addr = ^{araddr[ADDR_W-1:IW+2], araddr[1:0], awaddr[ADDR_W-1:IW+2], awaddr[1:0]};

  // Oldest eligible slot by wrap-aware seq difference; lowest free slot for allocation
  always_comb begin
    alloc = '0;
    pick = '0;
    pick_ok = 1'b0;
    age = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (!s_vld[i]) alloc = PW'(i);
    for (int i = 0; i < N_SLOTS; i++) begin
      age = s_seq[i] - s_seq[pick];
      if (s_vld[i] && s_cnt[i] == '0 && (!pick_ok || age[SW-1])) begin
        pick = PW'(i);
        pick_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_wp <= '0;
      aw_rp <= '0;
      w_wp <= '0;
      w_rp <= '0;
      aw_cnt <= '0;
      w_cnt <= '0;
      b_pending <= '0;
      s_vld <= '0;
      seq_ctr <= '0;
      rvalid <= 1'b0;
      rid <= '0;
      rdata <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_q[aw_wp] <= awaddr[IW+1:2];
        aw_wp <= inc(aw_wp);
      end
      if (wvalid && wready) begin
        w_q[w_wp] <= wdata;
        w_wp <= inc(w_wp);
      end
      if (commit) begin
        mem[aw_q[aw_rp]] <= w_q[w_rp];
        aw_rp <= inc(aw_rp);
        w_rp <= inc(w_rp);
      end
      aw_cnt <= aw_cnt + CW'(awvalid && awready) - CW'(commit);
      w_cnt <= w_cnt + CW'(wvalid && wready) - CW'(commit);
      b_pending <= b_pending + BW'(commit) - BW'(bvalid && bready);
      for (int i = 0; i < N_SLOTS; i++)
        if (load && pick == PW'(i)) s_vld[i] <= 1'b0;
        else if (s_cnt[i] != '0) s_cnt[i] <= s_cnt[i] - 1'b1;
      // mem is sampled before this edge's commit lands, so a same-cycle read sees old data
      if (arvalid && arready) begin
        s_vld[alloc] <= 1'b1;
        s_id[alloc] <= arid;
        s_data[alloc] <= mem[araddr[IW+1:2]];
        s_cnt[alloc] <= LW'(LAT_BASE + LAT_STEP * int'(arid));
        s_seq[alloc] <= seq_ctr;
        seq_ctr <= seq_ctr + 1'b1;
      end
      if (load) begin
        rvalid <= 1'b1;
        rid <= s_id[pick];
        rdata <= s_data[pick];
      end else if (rready) rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_slave_ooo_mem.sv
// tb_axi_slave_ooo_mem: directed timing scenarios plus randomized traffic against a reference memory
module tb_axi_slave_ooo_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [1:0] arid = '0;
  logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, rready = 1'b0, bready = 1'b0;
  logic arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0] rid;

  int n_tests = 0, n_fail = 0, cyc = 0, b_cnt = 0, rp = 0;
  bit rand_rr = 1'b0;
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q [4][$];
  int beat_id [$];
  logic [31:0] beat_data [$];
  int beat_cyc [$];
  logic prev_stall = 1'b0;
  logic [1:0] prev_rid;
  logic [31:0] prev_rdata;

  int e, e0, c, c0, bid, b0, b_exp, ops, nw, nr, n, mode, miss;
  logic [31:0] a, d, bd;
  logic [1:0] id;
  int sid_ids [5] = '{2, 2, 2, 2, 1};
  logic [31:0] sid_data [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 32'h22222222};

  axi_slave_ooo_mem dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arid(arid), .arvalid(arvalid), .arready(arready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rid(rid), .rvalid(rvalid), .rready(rready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Negedge sees the values that the next posedge will act on
  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_id", rid, prev_rid);
        chk("r_hold_data", rdata, prev_rdata);
      end
      prev_stall <= rvalid && !rready;
      prev_rid <= rid;
      prev_rdata <= rdata;
      if (rvalid && rready) begin
        beat_id.push_back(int'(rid));
        beat_data.push_back(rdata);
        beat_cyc.push_back(cyc);
      end
      if (bvalid && bready) b_cnt <= b_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rr) rready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_wr(input logic [31:0] ad, input logic [31:0] dd, input bit do_aw, input bit do_w);
    bit aw_r, w_r;
    int k;
    k = 0;
    awaddr = ad;
    wdata = dd;
    awvalid = do_aw;
    wvalid = do_w;
    while ((awvalid || wvalid) && k < 200) begin
      aw_r = awready;
      w_r = wready;
      tick();
      k++;
      if (aw_r) awvalid = 1'b0;
      if (w_r) wvalid = 1'b0;
    end
    chk("wr_accept", awvalid || wvalid, 0);
    awvalid = 1'b0;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] ad, input logic [1:0] idd, output int edge_n);
    bit r;
    int k;
    k = 0;
    araddr = ad;
    arid = idd;
    arvalid = 1'b1;
    while (arvalid && k < 200) begin
      r = arready;
      tick();
      k++;
      if (r) arvalid = 1'b0;
    end
    edge_n = cyc;
    chk("ar_accept", arvalid, 0);
    arvalid = 1'b0;
  endtask

  task automatic get_beat(output int bi, output logic [31:0] bdat, output int bc);
    int k;
    k = 0;
    while (beat_id.size() <= rp && k < 100) begin
      tick();
      k++;
    end
    chk("beat_arrive", beat_id.size() > rp, 1);
    if (beat_id.size() > rp) begin
      bi = beat_id[rp];
      bdat = beat_data[rp];
      bc = beat_cyc[rp];
      rp++;
    end else begin
      bi = -1;
      bdat = 'x;
      bc = -1;
    end
  endtask

  task automatic wait_b(input int target);
    int k;
    k = 0;
    while (b_cnt < target && k < 200) begin
      tick();
      k++;
    end
    chk("b_resp", b_cnt, target);
  endtask

  task automatic write_b(input logic [31:0] ad, input logic [31:0] dd);
    int t;
    t = b_cnt + 1;
    send_wr(ad, dd, 1, 1);
    wait_b(t);
    ref_mem[ad[5:2]] = dd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);

    send_wr(32'h100C, 32'hDEADBEEF, 1, 1);
    chk("b_early", bvalid, 0);
    tick();
    chk("b_latency", bvalid, 1);
    bready = 1'b1;
    tick();
    chk("b_clear", bvalid, 0);
    ref_mem[3] = 32'hDEADBEEF;
    rready = 1'b1;
    send_ar(32'h100C, 0, e);
    get_beat(bid, bd, c);
    chk("wr_rd_data", bd, 32'hDEADBEEF);
    chk("wr_rd_id", bid, 0);
    chk("wr_rd_lat", c - e, 1);

    write_b(32'h0, 32'h11111111);
    write_b(32'h4, 32'h22222222);
    send_ar(32'h0, 3, e0);
    send_ar(32'h4, 0, e);
    chk("ooo_b2b_ar", e - e0, 1);
    get_beat(bid, bd, c);
    chk("ooo_first_id", bid, 0);
    chk("ooo_first_data", bd, 32'h22222222);
    chk("ooo_first_lat", c - e, 1);
    get_beat(bid, bd, c);
    chk("ooo_second_id", bid, 3);
    chk("ooo_second_data", bd, 32'h11111111);
    chk("ooo_second_lat", c - e0, 10);

    write_b(32'h8, 32'h33333333);
    rready = 1'b0;
    send_ar(32'h0, 2, e0);
    send_ar(32'h4, 2, e);
    send_ar(32'h8, 2, e);
    send_ar(32'hC, 2, e);
    chk("slots_full", arready, 0);
    send_ar(32'h4, 1, e);
    chk("ar_after_load", e - e0, 8);
    repeat (12) tick();
    chk("stall_valid", rvalid, 1);
    chk("stall_id", rid, 2);
    chk("stall_data", rdata, 32'h11111111);
    rready = 1'b1;
    c0 = 0;
    for (int k = 0; k < 5; k++) begin
      get_beat(bid, bd, c);
      if (k == 0) c0 = c;
      chk("same_id_rid", bid, sid_ids[k]);
      chk("same_id_data", bd, sid_data[k]);
      chk("same_id_cycle", c - c0, k);
    end

    bready = 1'b0;
    b0 = b_cnt;
    send_wr(32'h8, 32'h55, 0, 1);
    repeat (5) tick();
    chk("dec_no_commit", bvalid, 0);
    send_wr(32'h8, 32'h55, 1, 0);
    ref_mem[2] = 32'h55;
    for (int k = 0; k < 5; k++) begin
      send_wr(32'h20 + 4 * k, 32'hA0 + k, 1, 1);
      ref_mem[8 + k] = 32'hA0 + k;
    end
    chk("dec_awready_low", awready, 0);
    chk("dec_wready_low", wready, 0);
    chk("dec_bvalid", bvalid, 1);
    chk("dec_no_b_yet", b_cnt - b0, 0);
    bready = 1'b1;
    n = 0;
    while (b_cnt - b0 < 6 && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("dec_b_total", b_cnt - b0, 6);
    chk("dec_b_idle", bvalid, 0);
    chk("dec_awready_back", awready, 1);
    send_ar(32'h8, 1, e);
    get_beat(bid, bd, c);
    chk("dec_rd_w_first", bd, 32'h55);
    send_ar(32'h30, 0, e);
    get_beat(bid, bd, c);
    chk("dec_rd_last", bd, 32'hA4);

    rready = 1'b0;
    bready = 1'b0;
    send_ar(32'hC, 3, e);
    send_ar(32'h0, 3, e);
    send_wr(32'h4, 32'h77, 1, 1);
    tick();
    chk("pre_rst_bvalid", bvalid, 1);
    rst = 1'b1;
    tick();
    chk("rst2_rvalid", rvalid, 0);
    chk("rst2_bvalid", bvalid, 0);
    chk("rst2_arready", arready, 1);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rready = 1'b1;
    bready = 1'b1;
    send_ar(32'hC, 0, e);
    get_beat(bid, bd, c);
    chk("rst2_mem3", bd, 0);
    chk("rst2_rid", bid, 0);

    rand_rr = 1'b1;
    b_exp = b_cnt;
    ops = 0;
    while (ops < 500) begin
      nw = $urandom_range(0, 3);
      nr = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        a = $urandom;
        d = $urandom;
        mode = $urandom_range(0, 2);
        if (mode == 0) send_wr(a, d, 1, 1);
        else begin
          send_wr(a, d, mode == 1, mode == 2);
          repeat ($urandom_range(0, 3)) tick();
          send_wr(a, d, mode == 2, mode == 1);
        end
        ref_mem[a[5:2]] = d;
        b_exp++;
      end
      wait_b(b_exp);
      for (int k = 0; k < nr; k++) begin
        a = $urandom;
        id = 2'($urandom_range(0, 3));
        exp_q[id].push_back(ref_mem[a[5:2]]);
        send_ar(a, id, e);
      end
      n = 0;
      while (beat_id.size() < rp + nr && n < 300) begin
        tick();
        n++;
      end
      while (rp < beat_id.size()) begin
        bid = beat_id[rp];
        bd = beat_data[rp];
        rp++;
        chk("rnd_beat_expected", exp_q[bid].size() != 0, 1);
        if (exp_q[bid].size() != 0) chk("rnd_data", bd, exp_q[bid].pop_front());
      end
      ops += nw + nr;
    end
    rand_rr = 1'b0;
    miss = 0;
    for (int i = 0; i < 4; i++) miss += exp_q[i].size();
    chk("rnd_missing", miss, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_slave_ooo_mem.md
# axi_slave_ooo_mem

AXI-lite slave responder with a small word memory, sitting directly downstream of the AXI master VIP and consuming its AR/AW/W channels. Writes are buffered and committed in order, with one B response each. Reads carry an ID, complete after an ID-dependent latency and may return out of order across IDs, always in order within an ID. It is synthesizable RTL and serves as the design under test for the pipelined-write / out-of-order-read master and monitor.

## Interface
- ADDR_W, 32, address width (matches addr_t)
- DATA_W, 32, data width (matches data_t)
- ID_W, 2, read ID width; n_ids = 2**ID_W
- MEM_WORDS, 16, memory depth; index = addr[$clog2(MEM_WORDS)+1:2]; other address bits ignored
- N_SLOTS, 4, outstanding read slots
- WR_FIFO_DEPTH, 2, depth of each of the AW and W buffers
- B_MAX, 4, maximum committed writes awaiting B handshake
- LAT_BASE, 0, read latency offset in cycles
- LAT_STEP, 3, extra read latency per ID unit
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- araddr  in  ADDR_W  read address
- arid  in  ID_W  read ID
- arvalid  in  1  / arready  out  1  AR handshake
- awaddr  in  ADDR_W  write address
- awvalid  in  1  / awready  out  1  AW handshake
- wdata  in  DATA_W  write data
- wvalid  in  1  / wready  out  1  W handshake
- rdata  out  DATA_W  read data
- rid  out  ID_W  read ID echo
- rvalid  out  1  / rready  in  1  R handshake
- bvalid  out  1  / bready  in  1  B handshake

## Operation
- Reset (rst high at an edge): FIFOs, slots and B counter cleared; memory cleared to 0; rvalid=0, bvalid=0, rdata=0, rid=0. arready, awready and wready read 1 once reset is deasserted. In-flight transactions are dropped.
- Ready outputs depend only on registered state, never on valid inputs: awready = AW FIFO not full; wready = W FIFO not full; arready = at least one free slot.
- Write path:
  - AW and W are accepted independently, in any relative order.
  - Commit happens when both FIFO heads are present and b_pending < B_MAX. Commit writes mem[index(awaddr)] = wdata, pops both heads and increments b_pending. At most one commit per cycle.
  - bvalid = (b_pending != 0). Each bvalid&bready decrements b_pending.
  - A commit and a B handshake in the same cycle leave b_pending unchanged.
- Read path:
  - On an AR handshake, allocate the lowest-index free slot and store {arid, mem[index(araddr)], countdown = LAT_BASE + LAT_STEP*arid, seq}.
  - seq comes from a free-running accept counter of width $clog2(N_SLOTS)+1.
  - A read samples memory before any commit in the same cycle.
  - Countdown decrements each cycle while nonzero. A slot with countdown 0 is eligible.
  - Output register {rvalid, rid, rdata} loads from the oldest eligible slot (smallest seq, compared modulo wrap) when rvalid=0 or rvalid&rready. The loaded slot is freed in that same cycle.
  - rvalid/rid/rdata stay stable while rvalid&!rready.
  - Oldest-first selection plus per-ID fixed latency guarantees in-order return within an ID.
- Out-of-range addresses alias through the index bits. No error responses are produced.

## Timing
- Write: AW and W both accepted at edge N → commit at edge N+1 → bvalid high after N+1. If W arrives later, the commit occurs at the edge after the later handshake.
- Read: AR accepted at edge N with L = LAT_BASE + LAT_STEP*arid → rvalid high after edge N+L+1 if the output register is free. Each stalled cycle (rvalid&!rready) adds one cycle.
- Back-to-back: rvalid stays high across consecutive handshakes when eligible slots exist. One R beat per cycle maximum.
- A slot freed at edge N is reflected in arready after N. There is no same-cycle free/allocate bypass.
- When b_pending == B_MAX, commits stall. The FIFOs then fill and awready/wready drop.

## Test plan
- Reset mid-traffic: rst asserted with 2 reads pending and bvalid=1 → after the reset edge rvalid=0, bvalid=0, arready=1, and mem[3] reads back 0.
- Write then read: write 0x100C=0xDEADBEEF, then read 0x100C with arid=0 and rready=1 → bvalid one cycle after the AW/W edge, rdata=0xDEADBEEF with rid=0 one cycle after the AR edge.
- Out of order: reads arid=3 (addr 0x0) then arid=0 (addr 0x4) on consecutive cycles → rid=0 is returned first (about 1 cycle after its AR); rid=3 follows 10 cycles after its AR.
- Same-ID ordering: 4 reads with arid=2 to addresses 0x0, 0x4, 0x8, 0xC, with rready low for 20 cycles and then high → 4 beats in issue order on consecutive cycles. A 5th AR sees arready=0 until the first beat is loaded.
- Decoupled write: W 0x55 is sent 5 cycles before AW 0x8, with bready=0 for 6 writes → bvalid stays high, awready/wready drop after B_MAX commits plus full FIFOs, and all 6 B responses arrive once bready=1.
- Random traffic: 500 mixed operations against a reference memory model → every rdata matches, with zero protocol errors in the monitor.
